// File: rtl/dec_rr_arbiter_if.sv
// rtl/dec_rr_arbiter_if.sv - request/grant bundle between requesters and the round-robin arbiter
interface dec_rr_arbiter_if;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;

    modport master (
        output en,
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_valid
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output gnt_id,
        output gnt_valid
    );
endinterface

// File: rtl/dec_rr_arbiter.sv
// rtl/dec_rr_arbiter.sv - four-way round-robin arbiter with decoded grant and hold-time limit
module dec_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input logic             clk,
    input logic             rst,
    dec_rr_arbiter_if.slave bus
);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [7:0] hold_cnt;

    logic [1:0] winner;
    logic [1:0] idx;
    logic       found;
    logic       contention;
    logic       revoke;

    // Scan from the farthest candidate back to ptr so the closest set bit wins.
    always_comb begin
        winner = ptr;
        idx    = ptr;
        found  = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (bus.req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign contention = |(bus.req & ~bus.gnt);
    assign revoke     = !bus.en || !bus.req[bus.gnt_id] ||
                        ((hold_cnt == HOLD_LAST) && contention);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= 2'd0;
            hold_cnt      <= 8'd0;
            bus.gnt       <= 4'b0000;
            bus.gnt_id    <= 2'd0;
            bus.gnt_valid <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.en && found) begin
                state         <= GRANT;
                bus.gnt_id    <= winner;
                bus.gnt       <= 4'b0001 << winner;
                bus.gnt_valid <= 1'b1;
                ptr           <= winner + 2'd1;
                hold_cnt      <= 8'd0;
            end
        end else begin
            // Every revocation returns to IDLE, which forces the one-cycle gap.
            if (revoke) begin
                state         <= IDLE;
                bus.gnt       <= 4'b0000;
                bus.gnt_valid <= 1'b0;
            end else if (hold_cnt != HOLD_LAST) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end
endmodule

// File: doc/dec_rr_arbiter.md
# dec_rr_arbiter

Four-requester round-robin arbiter that shares a single 2-to-4 decoded resource, such as the select lines of a 4-way bank or mux. It chooses one requester at a time and drives the encoded index plus a one-hot decoded grant. An enable gates all granting. A hold-time limit keeps one requester from starving the others.

## Interface
- MAX_HOLD, 8: maximum consecutive grant cycles while another requester is waiting; legal range 1..255.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- en  input  1  arbiter enable; when low, no new grant is issued and any active grant is revoked.
- req  input  4  request vector; req[i] is high while requester i wants the resource.
- gnt  output  4  one-hot grant; 4'b0000 when idle.
- gnt_id  output  2  encoded index of the granted requester; holds its last value while idle.
- gnt_valid  output  1  high exactly when gnt is non-zero.

## Operation
- All outputs are registered. Reset values: gnt=0, gnt_id=0, gnt_valid=0. Internal reset values: state=IDLE, ptr=0, hold_cnt=0.
- States: IDLE and GRANT.
- IDLE:
  - If en=1 and req≠0, pick the first set bit searching circularly from ptr (ptr, ptr+1, ... mod 4).
  - Then go to GRANT, set gnt_id=winner, gnt=decode(winner), gnt_valid=1, ptr=winner+1 mod 4 (3 wraps to 0), hold_cnt=0.
  - Otherwise stay in IDLE with outputs at 0.
- GRANT (owner = gnt_id). Checks run in priority order, first match wins:
  1. en=0: go to IDLE; gnt=0, gnt_valid=0.
  2. req[owner]=0 (release): go to IDLE; gnt=0, gnt_valid=0.
  3. hold_cnt=MAX_HOLD-1 and (req & ~gnt)≠0 (timeout with contention): go to IDLE; gnt=0, gnt_valid=0.
  4. Otherwise stay in GRANT. hold_cnt increments and saturates at MAX_HOLD-1.
- Leaving GRANT always passes through IDLE for at least one cycle, so there is a mandatory one-cycle gap between grants. This avoids two owners in the same cycle.
- ptr changes only when a grant is issued; revocations never change it.
- Changes to req bits other than the owner's have no effect during GRANT except for the timeout contention check.
- gnt_id keeps its last value in IDLE; consumers qualify it with gnt_valid.
- hold_cnt is 8 bits wide. With MAX_HOLD=1, a contended grant lasts exactly 1 cycle.

## Timing
- Grant latency: req and en sampled high at edge N give gnt valid after edge N.
- Release latency: req[owner] sampled low at edge N gives gnt=0 after edge N. The next grant appears after edge N+1 at the earliest.
- Timeout: with continuous contention, the owner holds the grant for exactly MAX_HOLD cycles. The gap is 1 cycle, so the period per requester is MAX_HOLD+1 cycles.
- Simultaneous release and timeout in the same cycle is treated as a release; the result is identical.
- en falling during GRANT revokes the grant at the next edge. en rising in IDLE allows a grant at the next edge.
- rst asserted at any time, including mid-grant, clears all outputs immediately without waiting for clk. The first grant after reset is evaluated at the first clk edge with rst low.

## Test plan
- Reset mid-grant: granted to 2, assert rst between edges → gnt=0, gnt_valid=0, gnt_id=0 before the next edge. After release of rst with req=4'b1000 → gnt=4'b1000, gnt_id=3.
- Single requester: en=1, req=4'b0100 → gnt=4'b0100, gnt_id=2 one edge later. Drop req[2] → gnt=0 one edge later.
- Full contention: MAX_HOLD=4, req=4'b1111 held → grant order 0,1,2,3,0. Each grant lasts 4 cycles followed by a 1-cycle gap (5-cycle period).
- Enable gating: en=0, req=4'b1111 for 10 cycles → gnt stays 0. During an active grant to 1, drop en → gnt=0 next edge and ptr stays at 2.
- No-contention hold: MAX_HOLD=4, only req[1] high for 20 cycles → gnt=4'b0010 continuously with no timeout gap.
- Pointer wrap: grant and release requester 3, then req=4'b1001 → next grant goes to 0 (ptr wrapped), not to 3.
